// File: rtl/snn_pkg.sv
// Constants and types shared between the spike dispatcher and the MAC array.
// The idle bus code lives here so both sides agree on "no address".
package snn_pkg;

    localparam int ADDR_W = 12;
    localparam logic [ADDR_W-1:0] IDLE_ADDR = 12'hFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DISPATCH,
        ST_CLEAR
    } state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/spike_prio_enc.sv
// Lowest-index-first priority encoder over the neuron spike vector.
// Produces the winning bit as one-hot, its binary index, and an any-set flag.
module spike_prio_enc #(
    parameter int NUM_NEURONS = 10,
    parameter int IDX_W       = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic [NUM_NEURONS-1:0] req,
    output logic [NUM_NEURONS-1:0] onehot,
    output logic [IDX_W-1:0]       idx,
    output logic                   any_set
);

    // Scanning from the top down lets the lowest set bit overwrite the rest.
    always_comb begin
        onehot = '0;
        idx    = '0;
        for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
            if (req[i]) begin
                onehot    = '0;
                onehot[i] = 1'b1;
                idx       = IDX_W'(i);
            end
        end
    end

    assign any_set = |req;

endmodule

// File: rtl/spike_dispatcher.sv
// Collects neuron spikes per timestep, serialises their source addresses onto
// the shared bus, then strobes timestep_clear so every MAC latches its sum.
module spike_dispatcher
    import snn_pkg::*;
#(
    parameter int                NUM_NEURONS  = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR    = '0,
    parameter int                CLEAR_CYCLES = 2
) (
    input  logic                   CLK_dispatch,
    input  logic                   rst,
    input  logic [NUM_NEURONS-1:0] spike_in,
    input  logic                   timestep_tick,
    output logic [ADDR_W-1:0]      source_address,
    output logic                   addr_valid,
    output logic                   timestep_clear,
    output logic                   timestep_done,
    output logic                   busy,
    output logic                   overrun_err,
    output logic [15:0]            spike_total
);

    localparam int IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam int CNT_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

    state_t                 state_q, state_d;
    logic [NUM_NEURONS-1:0] pending_q, pending_d;
    logic [NUM_NEURONS-1:0] snapshot_q, snapshot_d;
    logic                   tick_deferred_q, tick_deferred_d;
    logic [CNT_W-1:0]       clr_cnt_q, clr_cnt_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic                   valid_q, valid_d;
    logic                   clear_q, clear_d;
    logic                   done_q, done_d;
    logic                   busy_q, busy_d;
    logic                   overrun_q, overrun_d;
    logic [15:0]            total_q, total_d;

    logic [NUM_NEURONS-1:0] enc_req;
    logic [NUM_NEURONS-1:0] enc_onehot;
    logic [IDX_W-1:0]       enc_idx;
    logic                   enc_any;

    // In IDLE the encoder looks at the snapshot being taken right now, so the
    // first address is already registered on the edge that samples the tick.
    assign enc_req = (state_q == ST_IDLE) ? (pending_q | spike_in) : snapshot_q;

    spike_prio_enc #(
        .NUM_NEURONS (NUM_NEURONS),
        .IDX_W       (IDX_W)
    ) u_prio_enc (
        .req     (enc_req),
        .onehot  (enc_onehot),
        .idx     (enc_idx),
        .any_set (enc_any)
    );

    // NOTE: every signal gets a default at the top of always_comb; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_d         = state_q;
        pending_d       = pending_q | spike_in;
        snapshot_d      = snapshot_q;
        tick_deferred_d = tick_deferred_q;
        clr_cnt_d       = clr_cnt_q;
        addr_d          = IDLE_ADDR;
        valid_d         = 1'b0;
        clear_d         = 1'b0;
        done_d          = 1'b0;
        overrun_d       = overrun_q;
        total_d         = total_q;

        if (timestep_tick && (state_q != ST_IDLE)) begin
            overrun_d       = 1'b1;
            tick_deferred_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (timestep_tick || tick_deferred_q) begin
                    pending_d       = '0;
                    tick_deferred_d = 1'b0;
                end
            end
            ST_CLEAR: begin
                if (clr_cnt_q == '0) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    clr_cnt_d = clr_cnt_q - 1'b1;
                    clear_d   = 1'b1;
                end
            end
            default: ;
        endcase

        // Shared emit / start-clear step for the tick edge and DISPATCH.
        if ((state_q == ST_DISPATCH) ||
            ((state_q == ST_IDLE) && (timestep_tick || tick_deferred_q))) begin
            if (enc_any) begin
                state_d    = ST_DISPATCH;
                snapshot_d = enc_req & ~enc_onehot;
                addr_d     = BASE_ADDR + ADDR_W'(enc_idx);
                valid_d    = 1'b1;
                total_d    = sat_inc16(total_q);
            end else begin
                state_d    = ST_CLEAR;
                snapshot_d = '0;
                clear_d    = 1'b1;
                clr_cnt_d  = CNT_W'(CLEAR_CYCLES - 1);
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK_dispatch) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            pending_q       <= '0;
            snapshot_q      <= '0;
            tick_deferred_q <= 1'b0;
            clr_cnt_q       <= '0;
            addr_q          <= IDLE_ADDR;
            valid_q         <= 1'b0;
            clear_q         <= 1'b0;
            done_q          <= 1'b0;
            busy_q          <= 1'b0;
            overrun_q       <= 1'b0;
            total_q         <= '0;
        end else begin
            state_q         <= state_d;
            pending_q       <= pending_d;
            snapshot_q      <= snapshot_d;
            tick_deferred_q <= tick_deferred_d;
            clr_cnt_q       <= clr_cnt_d;
            addr_q          <= addr_d;
            valid_q         <= valid_d;
            clear_q         <= clear_d;
            done_q          <= done_d;
            busy_q          <= busy_d;
            overrun_q       <= overrun_d;
            total_q         <= total_d;
        end
    end

    assign source_address = addr_q;
    assign addr_valid     = valid_q;
    assign timestep_clear = clear_q;
    assign timestep_done  = done_q;
    assign busy           = busy_q;
    assign overrun_err    = overrun_q;
    assign spike_total    = total_q;

endmodule

// File: tb/tb_spike_dispatcher.sv
// Directed bench for spike_dispatcher: a table of per-cycle vectors followed by
// hand sequences for the overrun/deferred-tick and mid-sequence reset cases.
module tb_spike_dispatcher;

    localparam logic [11:0] IDLE = 12'hFFF;

    typedef struct {
        logic        rst;
        logic [9:0]  spike;
        logic        tick;
        logic [11:0] addr;
        logic        valid;
        logic        clr;
        logic        done;
        logic        busy;
        logic        ovr;
        logic [15:0] total;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [9:0]  spike_in;
    logic        timestep_tick;
    logic [11:0] source_address;
    logic        addr_valid;
    logic        timestep_clear;
    logic        timestep_done;
    logic        busy;
    logic        overrun_err;
    logic [15:0] spike_total;

    int checks   = 0;
    int failures = 0;
    vec_t vecs[$];

    spike_dispatcher dut (
        .CLK_dispatch   (clk),
        .rst            (rst),
        .spike_in       (spike_in),
        .timestep_tick  (timestep_tick),
        .source_address (source_address),
        .addr_valid     (addr_valid),
        .timestep_clear (timestep_clear),
        .timestep_done  (timestep_done),
        .busy           (busy),
        .overrun_err    (overrun_err),
        .spike_total    (spike_total)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs set now are sampled at the next rising edge; outputs are read 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic [9:0] s, input logic t,
                       input logic [11:0] a, input logic v, input logic c,
                       input logic d, input logic b, input logic o,
                       input logic [15:0] tot);
        vec_t e;
        e.rst = r; e.spike = s; e.tick = t; e.addr = a; e.valid = v;
        e.clr = c; e.done = d; e.busy = b; e.ovr = o; e.total = tot;
        vecs.push_back(e);
    endtask

    task automatic check_outputs(input string tag, input vec_t e);
        check({tag, ".addr"},  32'(source_address), 32'(e.addr));
        check({tag, ".valid"}, 32'(addr_valid),     32'(e.valid));
        check({tag, ".clear"}, 32'(timestep_clear), 32'(e.clr));
        check({tag, ".done"},  32'(timestep_done),  32'(e.done));
        check({tag, ".busy"},  32'(busy),           32'(e.busy));
        check({tag, ".ovr"},   32'(overrun_err),    32'(e.ovr));
        check({tag, ".total"}, 32'(spike_total),    32'(e.total));
    endtask

    initial begin
        int valid_seen;
        int cyc;
        rst = 1'b1;
        spike_in = '0;
        timestep_tick = 1'b0;

        //   rst  spike    tick addr    v  clr done busy ovr total
        add(1, 10'h000, 0, IDLE,    0, 0, 0, 0, 0, 16'd0);
        // spikes 0 and 2, tick three cycles later
        add(0, 10'h005, 0, IDLE,    0, 0, 0, 0, 0, 16'd0);
        add(0, 10'h000, 0, IDLE,    0, 0, 0, 0, 0, 16'd0);
        add(0, 10'h000, 0, IDLE,    0, 0, 0, 0, 0, 16'd0);
        add(0, 10'h000, 1, 12'd0,   1, 0, 0, 1, 0, 16'd1);
        add(0, 10'h000, 0, 12'd2,   1, 0, 0, 1, 0, 16'd2);
        add(0, 10'h000, 0, IDLE,    0, 1, 0, 1, 0, 16'd2);
        add(0, 10'h000, 0, IDLE,    0, 1, 0, 1, 0, 16'd2);
        add(0, 10'h000, 0, IDLE,    0, 0, 1, 0, 0, 16'd2);
        add(0, 10'h000, 0, IDLE,    0, 0, 0, 0, 0, 16'd2);
        // empty timestep still clears
        add(0, 10'h000, 1, IDLE,    0, 1, 0, 1, 0, 16'd2);
        add(0, 10'h000, 0, IDLE,    0, 1, 0, 1, 0, 16'd2);
        add(0, 10'h000, 0, IDLE,    0, 0, 1, 0, 0, 16'd2);
        add(0, 10'h000, 0, IDLE,    0, 0, 0, 0, 0, 16'd2);
        // all ten neurons fire in the tick cycle
        add(0, 10'h3FF, 1, 12'd0,   1, 0, 0, 1, 0, 16'd3);
        for (int k = 1; k < 10; k++)
            add(0, 10'h000, 0, 12'(k), 1, 0, 0, 1, 0, 16'(3 + k));
        add(0, 10'h000, 0, IDLE,    0, 1, 0, 1, 0, 16'd12);
        add(0, 10'h000, 0, IDLE,    0, 1, 0, 1, 0, 16'd12);
        add(0, 10'h000, 0, IDLE,    0, 0, 1, 0, 0, 16'd12);
        // neuron 4 fires while {1,7} dispatch; it waits for the next tick
        add(0, 10'h082, 0, IDLE,    0, 0, 0, 0, 0, 16'd12);
        add(0, 10'h000, 1, 12'd1,   1, 0, 0, 1, 0, 16'd13);
        add(0, 10'h010, 0, 12'd7,   1, 0, 0, 1, 0, 16'd14);
        add(0, 10'h000, 0, IDLE,    0, 1, 0, 1, 0, 16'd14);
        add(0, 10'h000, 0, IDLE,    0, 1, 0, 1, 0, 16'd14);
        add(0, 10'h000, 0, IDLE,    0, 0, 1, 0, 0, 16'd14);
        add(0, 10'h000, 1, 12'd4,   1, 0, 0, 1, 0, 16'd15);
        add(0, 10'h000, 0, IDLE,    0, 1, 0, 1, 0, 16'd15);
        add(0, 10'h000, 0, IDLE,    0, 1, 0, 1, 0, 16'd15);
        add(0, 10'h000, 0, IDLE,    0, 0, 1, 0, 0, 16'd15);
        add(0, 10'h000, 0, IDLE,    0, 0, 0, 0, 0, 16'd15);

        for (int i = 0; i < vecs.size(); i++) begin
            rst           = vecs[i].rst;
            spike_in      = vecs[i].spike;
            timestep_tick = vecs[i].tick;
            step();
            check_outputs($sformatf("row%0d", i), vecs[i]);
        end

        // Tick during CLEAR: sticky overrun, deferred tick restarts on its own.
        spike_in = 10'h001; timestep_tick = 1'b1;
        step();
        check("ovr.first_addr", 32'(source_address), 32'd0);
        spike_in = 10'h000; timestep_tick = 1'b0;
        step();
        check("ovr.clear_entry", 32'(timestep_clear), 32'd1);
        spike_in = 10'h008; timestep_tick = 1'b1;
        step();
        check("ovr.set", 32'(overrun_err), 32'd1);
        check("ovr.still_clear", 32'(timestep_clear), 32'd1);
        spike_in = 10'h000; timestep_tick = 1'b0;
        step();
        check("ovr.done", 32'(timestep_done), 32'd1);
        check("ovr.busy_low", 32'(busy), 32'd0);
        step();
        check("ovr.auto_addr", 32'(source_address), 32'd3);
        check("ovr.auto_valid", 32'(addr_valid), 32'd1);
        check("ovr.total", 32'(spike_total), 32'd17);
        cyc = 0;
        while (!timestep_done && cyc < 20) begin
            step();
            cyc++;
        end
        check("ovr.auto_done_seen", 32'(timestep_done), 32'd1);
        check("ovr.sticky", 32'(overrun_err), 32'd1);
        step();

        // Reset after the first of three addresses abandons the rest.
        spike_in = 10'h00E; timestep_tick = 1'b1;
        step();
        check("rst.first_addr", 32'(source_address), 32'd1);
        spike_in = 10'h000; timestep_tick = 1'b0; rst = 1'b1;
        step();
        check("rst.addr", 32'(source_address), 32'(IDLE));
        check("rst.valid", 32'(addr_valid), 32'd0);
        check("rst.clear", 32'(timestep_clear), 32'd0);
        check("rst.done", 32'(timestep_done), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.ovr", 32'(overrun_err), 32'd0);
        check("rst.total", 32'(spike_total), 32'd0);
        rst = 1'b0; timestep_tick = 1'b1;
        step();
        timestep_tick = 1'b0;
        check("rst.tick_clear", 32'(timestep_clear), 32'd1);
        valid_seen = int'(addr_valid);
        cyc = 0;
        while (!timestep_done && cyc < 10) begin
            step();
            valid_seen += int'(addr_valid);
            cyc++;
        end
        check("rst.done_seen", 32'(timestep_done), 32'd1);
        check("rst.no_addresses", 32'(valid_seen), 32'd0);
        check("rst.total_after", 32'(spike_total), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spike_dispatcher.md
Name: spike_dispatcher

Overview:
- Upstream stage of the MAC array: collects spike pulses from the NUM_NEURONS neuron units within one timestep.
- At timestep end it serialises the spiking neurons' 12-bit source addresses onto the shared source_address bus, one per cycle.
- It then drives the timestep clear pulse that makes every MAC latch its accumulated weight sum.
- Replaces the free-running clear counters inside each MAC with one central, deterministic sequencer.

Parameters:
- NUM_NEURONS, 10, number of neuron spike inputs.
- ADDR_W, 12, source address width.
- BASE_ADDR, 0, address of neuron 0; neuron i maps to BASE_ADDR+i.
- CLEAR_CYCLES, 2, cycles timestep_clear is held high (min 1).
- IDLE_ADDR, 12'hFFF, bus value when no address is valid; matches no MAC entry.

Ports:
- CLK_dispatch  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- spike_in  in  NUM_NEURONS  per-neuron spike, sampled every cycle; a high cycle means "fired this timestep".
- timestep_tick  in  1  single-cycle request to close the current timestep.
- source_address  out  ADDR_W  address broadcast to the MACs.
- addr_valid  out  1  source_address carries a real spike this cycle.
- timestep_clear  out  1  MAC latch/clear strobe.
- timestep_done  out  1  one-cycle pulse when the sequence completes.
- busy  out  1  high in any state other than IDLE.
- overrun_err  out  1  sticky; a tick arrived while busy.
- spike_total  out  16  saturating count of dispatched addresses since reset.

Behaviour:
- Reset (synchronous, rst=1 at a clock edge):
  - state=IDLE; pending, snapshot and tick_deferred cleared.
  - source_address=IDLE_ADDR; addr_valid, timestep_clear, timestep_done, busy, overrun_err = 0; spike_total=0.
  - Reset mid-sequence abandons all queued spikes.
- Capture:
  - pending <= pending | spike_in, every cycle, in all states.
  - Repeated pulses from one neuron within a timestep collapse to one event.
- States are IDLE, DISPATCH and CLEAR.
- IDLE:
  - On timestep_tick (or tick_deferred): snapshot <= pending | spike_in, pending <= 0, tick_deferred <= 0.
  - Go to DISPATCH if snapshot is nonzero, else go to CLEAR.
- DISPATCH:
  - Each cycle, a lowest-index-first priority encoder picks bit i of snapshot.
  - Drive source_address=BASE_ADDR+i and addr_valid=1 as registered outputs, clear bit i, and increment spike_total, saturating at 16'hFFFF.
  - After the last set bit is emitted, the next state is CLEAR.
  - Latency: tick sampled at edge T gives the first valid address in cycle T+1. N spikes occupy cycles T+1..T+N.
- CLEAR:
  - timestep_clear=1 for exactly CLEAR_CYCLES cycles; addr_valid=0 and source_address=IDLE_ADDR.
  - On the final CLEAR cycle, timestep_done=1 in the following cycle and state goes to IDLE.
  - busy drops in the same cycle timestep_done pulses.
- Address rules:
  - source_address holds IDLE_ADDR whenever addr_valid=0.
  - Addresses never gap within DISPATCH: back-to-back cycles, no stalls.
- Boundary cases:
  - Spike in the same cycle as an accepted tick goes into the current snapshot.
  - Spike during DISPATCH or CLEAR goes to pending and is sent next timestep, never into the running sequence.
  - Tick while busy: set overrun_err (sticky until rst) and set tick_deferred. The deferred tick is serviced on the first IDLE cycle. Multiple ticks while busy collapse to one.
  - All NUM_NEURONS spiking: the sequence takes NUM_NEURONS+CLEAR_CYCLES cycles after the tick.
  - Zero spikes: timestep_clear is still issued so the MACs output 0.
- Arithmetic:
  - BASE_ADDR+i is computed in ADDR_W bits; wrap-around is ignored.
  - Parameters must satisfy BASE_ADDR+NUM_NEURONS-1 < IDLE_ADDR.

Decomposition:
- Shared package (snn_pkg):
  - state enum IDLE/DISPATCH/CLEAR.
  - IDLE_ADDR and ADDR_W constants, shared with the MAC array so the idle code is common.
- One sub-module: spike_prio_enc.
  - Combinational, parameter NUM_NEURONS.
  - Outputs are a one-hot lowest-set bit, its binary index, and an any-set flag.
  - Used to select and clear the next snapshot bit.

Test Plan:
- Reset, then spike_in=10'b0000000101 for 1 cycle, tick 3 cycles later -> addresses 0 then 2 on consecutive cycles with addr_valid=1; then timestep_clear high 2 cycles, then timestep_done pulse; spike_total=2.
- Tick with no spikes -> no addr_valid; timestep_clear high 2 cycles starting the cycle after the tick; done pulse; spike_total unchanged.
- spike_in=10'h3FF in the same cycle as the tick -> addresses 0..9 in order over 10 consecutive cycles, then clear; busy high for 12 cycles.
- Neuron 4 spikes during DISPATCH of {1,7} -> current sequence emits only 1 and 7; the next tick emits only 4.
- Second tick during CLEAR -> overrun_err=1 and stays 1; after done, a new sequence starts automatically in the first IDLE cycle without a new tick.
- Assert rst mid-DISPATCH after 1 of 3 addresses -> next cycle source_address=12'hFFF and all flags 0; a subsequent tick with no spikes emits no addresses.
